heater_tx_scheduler: RTL and testbench

- Sequences the ring-oscillator heater (drives its ro_heating_enable) to transmit a message as temporal thermal bits: heat on for '1', heat off for '0', one bit per programmable period.
- Frames each message with a heating sync preamble and a cool-down guard interval.
- Snapshots the heater's 64-bit counter value at message end.
- Sits between the host-side control registers and the heater instance on the transmitter side of the covert-channel experiment.

---
 rtl/heater_ctrl_pkg.sv | 22 ++
 rtl/heater_period_timer.sv | 40 ++++
 rtl/heater_tx_scheduler.sv | 179 +++++++++++++++++
 tb/tb_heater_tx_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/heater_ctrl_pkg.sv
// Shared types and defaults for the heater transmit scheduler.
// Build option: HEATER_MANCHESTER_EN selects Manchester keying of data bits.
package heater_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_BIT,
      ST_GUARD,
      ST_DONE
   } state_e;

   localparam int DEF_MSG_W         = 64;
   localparam int DEF_PERIOD_W      = 32;
   localparam int DEF_SYNC_PERIODS  = 2;
   localparam int DEF_GUARD_PERIODS = 1;

   // Eight spare bits so (periods * bit period) never wraps.
   localparam int DEF_TIMER_W = DEF_PERIOD_W + 8;
   typedef logic [DEF_TIMER_W-1:0] timer_t;

endpackage

// File: rtl/heater_period_timer.sv
// Loadable down counter; tc is high while the count sits at zero.
// The next-cycle count is exported so callers can register outputs
// that depend on the position inside a period.
module heater_period_timer #(
   parameter int WIDTH = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count_next,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Load wins; otherwise count down and park at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_next = count_d;
   assign tc         = (count_q == '0);

endmodule

// File: rtl/heater_tx_scheduler.sv
// Drives the ring-oscillator heater enable to send a message as thermal
// bits: sync preamble (heat), data bits, guard (cool), one-cycle DONE.
// Build option: HEATER_MANCHESTER_EN splits each data bit into two halves.
module heater_tx_scheduler
   import heater_ctrl_pkg::*;
#(
   parameter int MSG_W         = DEF_MSG_W,
   parameter int PERIOD_W      = DEF_PERIOD_W,
   parameter int SYNC_PERIODS  = DEF_SYNC_PERIODS,
   parameter int GUARD_PERIODS = DEF_GUARD_PERIODS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [MSG_W-1:0]    msg_data,
   input  logic [7:0]          msg_bits,
   input  logic [PERIOD_W-1:0] bit_period,
   input  logic [63:0]         ro_heating_counter_value,
   output logic                ro_heating_enable,
   output logic                busy,
   output logic                done,
   output logic [7:0]          bit_idx,
   output logic [63:0]         counter_snapshot
);

   localparam int TW = PERIOD_W + 8;
   localparam logic [7:0] MSG_W_B = 8'(MSG_W);

   state_e              state_q, state_d;
   logic [MSG_W-1:0]    shreg_q, shreg_d;
   logic [7:0]          nbits_q, nbits_d;
   logic [7:0]          bit_idx_q, bit_idx_d;
   logic [PERIOD_W-1:0] eff_q, eff_d;
   logic                en_q, en_d;
   logic [63:0]         snap_q, snap_d;
   logic                enter;
   logic [TW-1:0]       load_value;
   logic [TW-1:0]       count_next;
   logic                tc;

   function automatic logic [TW-1:0] periods_of(input state_e s);
      case (s)
         ST_SYNC:  periods_of = TW'(SYNC_PERIODS);
         ST_BIT:   periods_of = TW'(1);
         ST_GUARD: periods_of = TW'(GUARD_PERIODS);
         default:  periods_of = '0;
      endcase
   endfunction

   function automatic state_e after_data();
      after_data = (GUARD_PERIODS > 0) ? ST_GUARD : ST_DONE;
   endfunction

   function automatic state_e after_sync(input logic [7:0] nbits);
      after_sync = (nbits != 8'd0) ? ST_BIT : after_data();
   endfunction

   heater_period_timer #(.WIDTH(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (enter),
      .load_value (load_value),
      .count_next (count_next),
      .tc         (tc)
   );

   // Next-state, datapath and registered-enable decode.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      nbits_d    = nbits_q;
      bit_idx_d  = bit_idx_q;
      eff_d      = eff_q;
      snap_d     = snap_q;
      enter      = 1'b0;
      en_d       = 1'b0;
      load_value = '0;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
`ifdef HEATER_MANCHESTER_EN
               eff_d = (bit_period < PERIOD_W'(2)) ? PERIOD_W'(2) : bit_period;
`else
               eff_d = (bit_period == '0) ? PERIOD_W'(1) : bit_period;
`endif
               shreg_d   = msg_data;
               nbits_d   = (msg_bits > MSG_W_B) ? MSG_W_B : msg_bits;
               bit_idx_d = 8'd0;
               state_d   = (SYNC_PERIODS > 0) ? ST_SYNC : after_sync(nbits_d);
               enter     = 1'b1;
            end
         end
         ST_SYNC: begin
            if (tc) begin
               state_d = after_sync(nbits_q);
               enter   = 1'b1;
            end
         end
         ST_BIT: begin
            if (tc) begin
               enter = 1'b1;
               if (bit_idx_q == nbits_q - 8'd1) begin
                  state_d = after_data();
               end else begin
                  shreg_d   = shreg_q >> 1;
                  bit_idx_d = bit_idx_q + 8'd1;
               end
            end
         end
         ST_GUARD: begin
            if (tc) begin
               state_d = ST_DONE;
               enter   = 1'b1;
            end
         end
         ST_DONE: begin
            snap_d  = ro_heating_counter_value;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort cancels without a done pulse or a new snapshot.
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         enter   = 1'b0;
         snap_d  = snap_q;
      end

      load_value = periods_of(state_d) * TW'(eff_d) - TW'(1);

      // Enable reflects the state/position of the coming cycle.
      case (state_d)
         ST_SYNC: en_d = 1'b1;
`ifdef HEATER_MANCHESTER_EN
         ST_BIT:  en_d = (count_next >= (TW'(eff_d) - (TW'(eff_d) >> 1)))
                         ? shreg_d[0] : ~shreg_d[0];
`else
         ST_BIT:  en_d = shreg_d[0];
`endif
         default: en_d = 1'b0;
      endcase
   end

`ifndef HEATER_MANCHESTER_EN
   logic unused_count;
   assign unused_count = ^count_next;
`endif

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         nbits_q   <= 8'd0;
         bit_idx_q <= 8'd0;
         eff_q     <= PERIOD_W'(1);
         en_q      <= 1'b0;
         snap_q    <= 64'd0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         nbits_q   <= nbits_d;
         bit_idx_q <= bit_idx_d;
         eff_q     <= eff_d;
         en_q      <= en_d;
         snap_q    <= snap_d;
      end
   end

   assign ro_heating_enable = en_q;
   assign busy              = (state_q != ST_IDLE);
   assign done              = (state_q == ST_DONE);
   assign bit_idx           = bit_idx_q;
   assign counter_snapshot  = snap_q;

endmodule

// File: tb/tb_heater_tx_scheduler.sv
// Directed bench for heater_tx_scheduler: a waveform model pushes the
// expected per-cycle outputs to a queue; they are popped and compared
// on the falling edge while the DUT runs.
module tb_heater_tx_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start0, abort, abort0;
   logic [63:0] msg_data;
   logic [7:0]  msg_bits;
   logic [31:0] bit_period;
   logic [63:0] cnt;

   logic        en, busy, done;
   logic [7:0]  bit_idx;
   logic [63:0] snap;
   logic        en0, busy0, done0;
   logic [7:0]  bit_idx0;
   logic [63:0] snap0;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       en;
      logic       busy;
      logic       done;
      logic       idx_chk;
      logic [7:0] idx;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   heater_tx_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .msg_data(msg_data), .msg_bits(msg_bits), .bit_period(bit_period),
      .ro_heating_counter_value(cnt),
      .ro_heating_enable(en), .busy(busy), .done(done),
      .bit_idx(bit_idx), .counter_snapshot(snap)
   );

   heater_tx_scheduler #(.SYNC_PERIODS(0), .GUARD_PERIODS(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .abort(abort0),
      .msg_data(msg_data), .msg_bits(msg_bits), .bit_period(bit_period),
      .ro_heating_counter_value(cnt),
      .ro_heating_enable(en0), .busy(busy0), .done(done0),
      .bit_idx(bit_idx0), .counter_snapshot(snap0)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Expected waveform of one transmission, starting with the first busy cycle.
   task automatic push_tx(input logic [63:0] data, input logic [7:0] bits,
                          input logic [31:0] period, input int sync, input int guard);
      int  eff, nb;
      logic b, e;
      eff = (period == 0) ? 1 : int'(period);
`ifdef HEATER_MANCHESTER_EN
      if (eff < 2) eff = 2;
`endif
      nb = (bits > 8'd64) ? 64 : int'(bits);
      for (int i = 0; i < sync * eff; i++) q.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'd0});
      for (int i = 0; i < nb; i++) begin
         b = data[i];
         for (int j = 0; j < eff; j++) begin
`ifdef HEATER_MANCHESTER_EN
            e = (j < eff / 2) ? b : ~b;
`else
            e = b;
`endif
            q.push_back('{e, 1'b1, 1'b0, 1'b1, 8'(i)});
         end
      end
      for (int i = 0; i < guard * eff; i++) q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'd0});
      q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
      q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
   endtask

   task automatic do_start(input bit sel);
      if (sel) start0 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start0 = 1'b0;
   endtask

   // Pops one expectation per cycle; ev_kind 1 = extra start, 2 = abort,
   // applied during cycle ev_cycle.
   task automatic drain(input bit sel, input int ev_cycle, input int ev_kind);
      exp_t x;
      int   c;
      c = 1;
      while (q.size() > 0) begin
         x = q.pop_front();
         chk($sformatf("c%0d enable", c), sel ? 64'(en0) : 64'(en), 64'(x.en));
         chk($sformatf("c%0d busy", c), sel ? 64'(busy0) : 64'(busy), 64'(x.busy));
         chk($sformatf("c%0d done", c), sel ? 64'(done0) : 64'(done), 64'(x.done));
         if (x.idx_chk)
            chk($sformatf("c%0d bit_idx", c), sel ? 64'(bit_idx0) : 64'(bit_idx), 64'(x.idx));
         if (c == ev_cycle && ev_kind == 1) begin
            start    = 1'b1;
            msg_data = 64'h4;
         end
         if (c == ev_cycle && ev_kind == 2) abort = 1'b1;
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         c++;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " enable"}, 64'(en), 64'd0);
      chk({tag, " busy"}, 64'(busy), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd0);
      chk({tag, " bit_idx"}, 64'(bit_idx), 64'd0);
      chk({tag, " snapshot"}, snap, 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start0 = 1'b0; abort = 1'b0; abort0 = 1'b0;
      msg_data = 64'hB; msg_bits = 8'd4; bit_period = 32'd4; cnt = 64'd111110;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Nominal transmission.
      push_tx(64'hB, 8'd4, 32'd4, 2, 1);
      do_start(1'b0);
      drain(1'b0, 0, 0);
      chk("nominal snapshot", snap, 64'd111110);
      $display("nominal transmission done");

      // Start while busy is ignored.
      push_tx(64'hB, 8'd4, 32'd4, 2, 1);
      do_start(1'b0);
      drain(1'b0, 5, 1);
      chk("busy-start snapshot", snap, 64'd111110);
      $display("start-while-busy transmission done");

      // Abort at cycle 10: idle from cycle 11, no done, snapshot held.
      msg_data = 64'hB;
      cnt = 64'd222;
      push_tx(64'hB, 8'd4, 32'd4, 2, 1);
      while (q.size() > 10) void'(q.pop_back());
      repeat (3) q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
      do_start(1'b0);
      drain(1'b0, 10, 2);
      chk("abort snapshot", snap, 64'd111110);
      $display("abort transmission done");

      // Abort in IDLE blocks a same-cycle start.
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("idle-abort busy", 64'(busy), 64'd0);
      chk("idle-abort enable", 64'(en), 64'd0);
      $display("idle abort blocking start done");

      // Zero bit period runs at the minimum effective period.
      msg_data = 64'h1; msg_bits = 8'd2; bit_period = 32'd0;
      push_tx(64'h1, 8'd2, 32'd0, 2, 1);
      do_start(1'b0);
      drain(1'b0, 0, 0);
      chk("period0 snapshot", snap, 64'd222);
      $display("zero bit_period transmission done");

      // msg_bits above MSG_W is clamped.
      msg_data = {$urandom, $urandom}; msg_bits = 8'd70; bit_period = 32'd1;
      cnt = 64'h0123_4567_89AB_CDEF;
      push_tx(msg_data, 8'd70, 32'd1, 2, 1);
      do_start(1'b0);
      drain(1'b0, 0, 0);
      chk("clamp snapshot", snap, 64'h0123_4567_89AB_CDEF);
      $display("clamped-length transmission done");

      // Zero-length message with no preamble and no guard.
      msg_bits = 8'd0; bit_period = 32'd4; cnt = 64'd777;
      push_tx(msg_data, 8'd0, 32'd4, 0, 0);
      do_start(1'b1);
      drain(1'b1, 0, 0);
      chk("zero-length snapshot", snap0, 64'd777);
      $display("zero-length transmission done");

      // Asynchronous reset during cycle 12.
      msg_data = 64'hB; msg_bits = 8'd4; bit_period = 32'd4; cnt = 64'd111110;
      push_tx(64'hB, 8'd4, 32'd4, 2, 1);
      while (q.size() > 11) void'(q.pop_back());
      do_start(1'b0);
      drain(1'b0, 0, 0);
      rst = 1'b1;
      #1;
      chk_all_zero("async-rst");
      #1 rst = 1'b0;
      @(negedge clk);
      $display("async reset mid-transmission done");

      // Nominal again after the reset.
      push_tx(64'hB, 8'd4, 32'd4, 2, 1);
      do_start(1'b0);
      drain(1'b0, 0, 0);
      chk("post-rst snapshot", snap, 64'd111110);
      $display("post-reset nominal transmission done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
